// File: rtl/shiftmix_stage.sv
// shiftmix_stage
//   AES-128 round stage between SubBytes and AddRoundKey. ShiftRows is applied
//   combinationally on accept. MixColumns is then applied one 32-bit column
//   per clock, over four cycles. Last-round states skip MixColumns.
// Ports
//   clk, rst               : clock and async active-high reset
//   in_valid/in_ready      : input handshake for state_in + last_round
//   state_in   [127:0]     : SubBytes output, byte k at [127-8k -: 8], row k%4, col k/4
//   last_round             : skip MixColumns for this state
//   out_valid/out_ready    : output handshake for state_out
//   state_out  [127:0]     : result, same byte order as state_in
module shiftmix_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic         out_valid_q, out_valid_d;
  logic         accept;
  logic [127:0] shifted;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word layout: a0 (row 0) in the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Output byte (r,c) takes input byte (r,(c+r)%4); byte index is 4*col+row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  assign shifted   = shift_rows(state_in);
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign state_out = work_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE, DONE: begin
        // In DONE an accept also consumes the held result on the same edge.
        if (accept) begin
          work_d = shifted;
          if (last_round) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d     = MIX;
            col_d       = 2'd0;
            out_valid_d = 1'b0;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      MIX: begin
        for (int c = 0; c < 4; c++)
          if (col_q == 2'(c))
            work_d[127-32*c -: 32] = mix_col(work_q[127-32*c -: 32]);
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_shiftmix_stage.sv
// Testbench for shiftmix_stage: directed FIPS-197 vectors plus randomized
// rounds checked against a byte-matrix AES reference model.
module tb_shiftmix_stage;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [127:0] R1_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] R1_OUT  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] R10_IN  = 128'he9098972cb31075f3d327d94af2e2cb5;
  localparam logic [127:0] R10_OUT = 128'he9317db5cb322c723d2e895faf090794;

  shiftmix_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .last_round(last_round), .out_valid(out_valid),
    .out_ready(out_ready), .state_out(state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // GF(2^8) multiply, shift-and-add with reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // State as a 4x4 byte matrix; ShiftRows then (optionally) the MixColumns matrix product.
  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic last);
    logic [7:0]   m [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   o [4][4];
    logic [7:0]   coef;
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = s[127-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = m[r][(c+r)%4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (last) o[r][c] = t[r][c];
        else begin
          o[r][c] = 8'h00;
          for (int k = 0; k < 4; k++) begin
            case ((k - r + 4) % 4)
              0:       coef = 8'h02;
              1:       coef = 8'h03;
              default: coef = 8'h01;
            endcase
            o[r][c] = o[r][c] ^ gmul(coef, t[k][c]);
          end
        end
      end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = o[r][c];
    return res;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one input for a single edge (caller guarantees in_ready).
  task automatic push(input logic [127:0] d, input logic last);
    state_in   = d;
    last_round = last;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; state_in = '0; last_round = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01 || state_out !== '0)
      $display("FAIL reset_state got v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, state_out);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01 || state_out !== '0)
      $display("FAIL reset_idle got v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, state_out);
    else pass_cnt++;
    // Park a result in DONE, then reset asynchronously mid-cycle.
    push(R10_IN, 1'b1);
    #3 rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01 || state_out !== '0)
      $display("FAIL reset_async got v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, state_out);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_round;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL round1_ready_idle got %b want 1", in_ready);
    else pass_cnt++;
    push(R1_IN, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;  // must be ignored while mixing
      total_cnt++;
      if ({in_ready, out_valid} !== 2'b00)
        $display("FAIL round1_mix_cyc%0d got r=%b v=%b want r=0 v=0", i, in_ready, out_valid);
      else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || state_out !== R1_OUT)
      $display("FAIL round1_result got v=%b d=%h want v=1 d=%h", out_valid, state_out, R1_OUT);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL round1_consume got v=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_last_round;
    push(R10_IN, 1'b1);
    total_cnt++;
    if (out_valid !== 1'b1 || state_out !== R10_OUT)
      $display("FAIL last_result got v=%b d=%h want v=1 d=%h", out_valid, state_out, R10_OUT);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL last_consume got v=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    push(R1_IN, 1'b0);
    repeat (4) tick();
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || state_out !== R1_OUT || in_ready !== 1'b0)
        $display("FAIL bp_hold_cyc%0d got v=%b r=%b d=%h want v=1 r=0 d=%h",
                 i, out_valid, in_ready, state_out, R1_OUT);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [127:0] d;
    push(R10_IN, 1'b1);
    state_in = '0; last_round = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || state_out !== R10_OUT)
      $display("FAIL b2b_handoff got r=%b v=%b d=%h want r=1 v=1 d=%h", in_ready, out_valid, state_out, R10_OUT);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL b2b_mix_cyc%0d got v=%b want 0", i, out_valid);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (out_valid !== 1'b1 || state_out !== '0)
      $display("FAIL b2b_zero_result got v=%b d=%h want v=1 d=0", out_valid, state_out);
    else pass_cnt++;
    tick();  // consumed with out_ready still high
    // Stream last-round states at one per cycle.
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      state_in = d; last_round = 1'b1; in_valid = 1'b1;
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || state_out !== ref_round(d, 1'b1))
        $display("FAIL b2b_stream%0d got v=%b d=%h want v=1 d=%h", i, out_valid, state_out, ref_round(d, 1'b1));
      else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain got v=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_mix;
    push(R1_IN, 1'b0);
    tick(); tick();  // two columns done, third column addressed
    #3 rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || state_out !== '0 || in_ready !== 1'b1)
      $display("FAIL midmix_reset got v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, state_out);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL midmix_no_pulse%0d got v=%b want 0", i, out_valid);
      else pass_cnt++;
      tick();
    end
    push(R1_IN, 1'b0);
    repeat (3) tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL midmix_early got v=%b want 0", out_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || state_out !== R1_OUT)
      $display("FAIL midmix_fresh got v=%b d=%h want v=1 d=%h", out_valid, state_out, R1_OUT);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [127:0] d, exp;
    logic         last;
    int           bp;
    for (int n = 0; n < 16; n++) begin
      d    = {$urandom, $urandom, $urandom, $urandom};
      last = 1'($urandom_range(0, 1));
      exp  = ref_round(d, last);
      push(d, last);
      if (!last) begin
        for (int i = 0; i < 4; i++) begin
          total_cnt++;
          if (out_valid !== 1'b0) $display("FAIL rand%0d_latency cyc%0d got v=%b want 0", n, i, out_valid);
          else pass_cnt++;
          tick();
        end
      end
      bp = int'($urandom_range(0, 3));
      for (int i = 0; i <= bp; i++) begin
        total_cnt++;
        if (out_valid !== 1'b1 || state_out !== exp)
          $display("FAIL rand%0d_result got v=%b d=%h want v=1 d=%h", n, out_valid, state_out, exp);
        else pass_cnt++;
        if (i < bp) tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL rand%0d_consume got v=%b want 0", n, out_valid);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_fips_round();
    test_last_round();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mix();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/shiftmix_stage.md
# shiftmix_stage

Registered, column-serial ShiftRows + MixColumns stage placed directly downstream of the combinational `subbytes` block in the AES-128 cipher round. It takes the 128-bit SubBytes output through a valid/ready handshake, applies ShiftRows, then applies MixColumns one 32-bit column per clock. Final-round states bypass MixColumns. The result is presented on a valid/ready output toward AddRoundKey.

## Interface
- No parameters. Data width is fixed at 128 bits (16 bytes, 4 columns).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `in_valid`  in  1  `state_in` and `last_round` are valid.
- `in_ready`  out  1  stage can accept an input this cycle.
- `state_in`  in  128  SubBytes output. Byte k occupies bits [127-8k:120-8k] and maps to row k%4, column k/4 (FIPS-197 column-major order).
- `last_round`  in  1  when high, MixColumns is skipped for this input (round 10).
- `out_valid`  out  1  `state_out` holds a completed result.
- `out_ready`  in  1  downstream accepts `state_out` this cycle.
- `state_out`  out  128  ShiftRows(+MixColumns) result, same byte order as `state_in`.

## Operation
- FSM states: IDLE, MIX, DONE. A 2-bit column counter `col` is used in MIX.
- ShiftRows is combinational on `state_in`: output byte (r,c) = input byte (r,(c+r) mod 4).
- `in_ready` = (state==IDLE) || (state==DONE && out_ready).
- Accept condition: `in_valid && in_ready`. On accept, the shifted state is loaded into the work register, which drives `state_out`.
  - If `last_round`=0: next state MIX, `col`=0.
  - If `last_round`=1: next state DONE.
- MIX, per edge: column `col` of the work register is replaced by MixColumns(column); `col` increments.
  - When `col`==3, the next state is DONE.
  - Only the addressed column changes; the other columns hold.
- MixColumns on column (a0,a1,a2,a3): b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
  - 2x = xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 8'h00).
  - 3x = xtime(x)^x. All arithmetic is 8-bit GF(2^8); no carries.
- DONE: `out_valid`=1 and `state_out` is held stable until `out_ready`=1.
  - On `out_ready` without a new accept, next state is IDLE.
  - On `out_ready` with a simultaneous accept (back-to-back), load the new input per the accept rules. The old result is consumed on the same edge.
- `in_valid` in MIX is ignored; the input is not consumed because `in_ready`=0.
- Reset, async and effective mid-operation: state IDLE, `col`=0, work register = 0, `out_valid`=0, `in_ready`=1, `state_out`=0. A partially mixed state is discarded, with no output.

## Timing
- Normal round: accept at edge E. The columns update at edges E+1..E+4, and `out_valid` goes high after edge E+4. Latency is 4 cycles.
- Last round: accept at edge E; `out_valid` goes high after edge E. Latency is 1 cycle.
- Throughput with `out_ready` held high: one normal round per 5 cycles, or one last round per cycle (back-to-back).
- `in_ready` depends combinationally on `out_ready` in DONE only. There is no combinational path from `in_valid` or `state_in` to any output other than through registers.
- `out_valid` is a pure register output, and `state_out` is a register output.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → immediately `out_valid`=0, `state_out`=0, `in_ready`=1. Release, then idle 3 cycles → outputs unchanged.
- FIPS-197 round 1, `last_round`=0: input d42711aee0bf98f1b8b45de51e415230 → after 4 cycles, `out_valid`=1 with `state_out`=046681e5e0cb199a48f8d37a2806264c; `in_ready`=0 during MIX.
- Last round, `last_round`=1: input e9098972cb31075f3d327d94af2e2cb5 → one cycle later, `out_valid`=1 with `state_out`=e9317db5cb322c723d2e895faf090794.
- Backpressure: complete the round-1 vector with `out_ready`=0 for 6 cycles → `state_out` stays stable and `out_valid` stays 1. Raise `out_ready` → IDLE next cycle, `out_valid`=0.
- Back-to-back: in DONE with `out_ready`=1 and a new `in_valid`, both transfers complete on the same edge. The second result (all-zero input, `last_round`=0) gives 00…00 after 4 cycles.
- Reset mid-MIX: assert `rst` at `col`=2 → no `out_valid` pulse. After release, a fresh round-1 vector yields the correct result with 4-cycle latency.
